// File: rtl/memory_stage.sv
// RV32I MEM stage: data-memory req/gnt/rvalid handshake, load alignment/extension and the MEM/WB register.
// Optional macro MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating the low address bits.
module memory_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              EX_valid,
  input  logic              EX_mem_read,
  input  logic              EX_mem_write,
  input  logic              EX_reg_write,
  input  logic [2:0]        EX_funct3,
  input  logic [31:0]       EX_ALU_result,
  input  logic [DATA_W-1:0] EX_store_data,
  input  logic [4:0]        EX_rd,
  input  logic [31:0]       EX_PC,
  output logic              MEM_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              EX_MEM_reg_write_reg,
  output logic [4:0]        EX_MEM_rd_reg,
  output logic [DATA_W-1:0] EX_RF_WR_Data_reg,
  output logic [31:0]       MEM_PC_reg,
  output logic              mem_trap,
  output logic [3:0]        mem_trap_cause,
  output logic [31:0]       mem_trap_tval
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t              state, state_nxt;
  logic                discard, discard_nxt;
  logic                is_load, mem_acc, misalign, trap_hit, rd_ok;
  logic                req, wb_we;
  logic [1:0]          acc_size, off;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wb_data;

  function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] word,
                                                 input logic [1:0] lane,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic [DATA_W-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    load_fmt = uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                              : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      SZ_H:    load_fmt = uns ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                              : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default: load_fmt = word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_fmt(input logic [DATA_W-1:0] data,
                                                  input logic [1:0] size);
    case (size)
      SZ_B:    store_fmt = {4{data[7:0]}};
      SZ_H:    store_fmt = {2{data[15:0]}};
      default: store_fmt = data;
    endcase
  endfunction

  assign is_load = EX_mem_read;
  assign mem_acc = EX_valid && (EX_mem_read || EX_mem_write);
  assign rd_ok   = EX_reg_write && (EX_rd != 5'd0);

  // Loads decode size from funct3[1:0] (LBU/LHU share it); stores only know SB/SH, the rest is SW.
  always_comb begin
    acc_size = SZ_W;
    if (is_load) begin
      case (EX_funct3[1:0])
        2'b00:   acc_size = SZ_B;
        2'b01:   acc_size = SZ_H;
        default: acc_size = SZ_W;
      endcase
    end else begin
      case (EX_funct3)
        3'b000:  acc_size = SZ_B;
        3'b001:  acc_size = SZ_H;
        default: acc_size = SZ_W;
      endcase
    end
  end

  assign misalign = ((acc_size == SZ_H) && EX_ALU_result[0]) ||
                    ((acc_size == SZ_W) && (EX_ALU_result[1:0] != 2'b00));

`ifdef MISALIGN_TRAP_EN
  assign trap_hit = mem_acc && misalign;
  assign off      = EX_ALU_result[1:0];
`else
  assign trap_hit = 1'b0;
  assign off      = (acc_size == SZ_B) ? EX_ALU_result[1:0] :
                    (acc_size == SZ_H) ? {EX_ALU_result[1], 1'b0} : 2'b00;
`endif

  always_comb begin
    case (acc_size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  // Request fields derive from EX/MEM, which is held stable while stalled.
  assign dmem_req   = req;
  assign dmem_we    = req && EX_mem_write && !EX_mem_read;
  assign dmem_addr  = req ? {EX_ALU_result[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = req ? be : 4'b0000;
  assign dmem_wdata = req ? store_fmt(EX_store_data, acc_size) : '0;
  assign MEM_stall  = (state == RESP) ? !dmem_rvalid : (req && !(dmem_gnt && !is_load));

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    req         = 1'b0;
    wb_we       = 1'b0;
    wb_data     = EX_ALU_result;
    case (state)
      IDLE: begin
        if (!flush && mem_acc && !trap_hit) begin
          req = 1'b1;
          if (!dmem_gnt)    state_nxt = REQ;
          else if (is_load) state_nxt = RESP;
        end else if (!flush && EX_valid && !mem_acc) begin
          wb_we = rd_ok;
        end
      end
      REQ: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          req = 1'b1;
          if (dmem_gnt) state_nxt = is_load ? RESP : IDLE;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_nxt   = IDLE;
          discard_nxt = 1'b0;
          wb_data     = load_fmt(dmem_rdata, off, acc_size, EX_funct3[2]);
          wb_we       = !discard && !flush && rd_ok;
        end else if (flush) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MEM/WB boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      discard              <= 1'b0;
      EX_MEM_reg_write_reg <= 1'b0;
      EX_MEM_rd_reg        <= '0;
      EX_RF_WR_Data_reg    <= '0;
      MEM_PC_reg           <= '0;
    end else begin
      state                <= state_nxt;
      discard              <= discard_nxt;
      EX_MEM_reg_write_reg <= wb_we;
      EX_MEM_rd_reg        <= EX_rd;
      EX_RF_WR_Data_reg    <= wb_data;
      MEM_PC_reg           <= EX_PC;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_fire;
  assign trap_fire = (state == IDLE) && trap_hit && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_trap       <= 1'b0;
      mem_trap_cause <= '0;
      mem_trap_tval  <= '0;
    end else begin
      mem_trap       <= trap_fire;
      mem_trap_cause <= trap_fire ? (is_load ? 4'd4 : 4'd6) : 4'd0;
      mem_trap_tval  <= trap_fire ? EX_ALU_result : 32'd0;
    end
  end
`else
  assign mem_trap       = 1'b0;
  assign mem_trap_cause = 4'd0;
  assign mem_trap_tval  = 32'd0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized ALU/load/store traffic against a byte-level model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        EX_valid, EX_mem_read, EX_mem_write, EX_reg_write;
  logic [2:0]  EX_funct3;
  logic [31:0] EX_ALU_result, EX_store_data, EX_PC;
  logic [4:0]  EX_rd;
  logic        MEM_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        EX_MEM_reg_write_reg, mem_trap;
  logic [4:0]  EX_MEM_rd_reg;
  logic [31:0] EX_RF_WR_Data_reg, MEM_PC_reg, mem_trap_tval;
  logic [3:0]  mem_trap_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .EX_valid(EX_valid), .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write),
    .EX_reg_write(EX_reg_write), .EX_funct3(EX_funct3), .EX_ALU_result(EX_ALU_result),
    .EX_store_data(EX_store_data), .EX_rd(EX_rd), .EX_PC(EX_PC),
    .MEM_stall(MEM_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .EX_MEM_reg_write_reg(EX_MEM_reg_write_reg), .EX_MEM_rd_reg(EX_MEM_rd_reg),
    .EX_RF_WR_Data_reg(EX_RF_WR_Data_reg), .MEM_PC_reg(MEM_PC_reg),
    .mem_trap(mem_trap), .mem_trap_cause(mem_trap_cause), .mem_trap_tval(mem_trap_tval)
  );

  // ---- reference model: access width in bytes, lane offset, byte enables, data formatting
  function automatic int nbytes(input bit ld, input logic [2:0] f3);
    if (ld) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        default:    return 4;
      endcase
    end
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int lane(input int n, input logic [31:0] addr);
    return (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] exp_be(input int n, input logic [31:0] addr);
    return 4'(((1 << n) - 1) << lane(n, addr));
  endfunction

  function automatic logic [31:0] exp_wdata(input int n, input logic [31:0] sd);
    longint m, d, w;
    m = longint'(1) << (8 * n);
    d = longint'(sd) % m;
    w = 0;
    for (int k = 0; k < 4 / n; k++) w = w | (d << (8 * n * k));
    return w[31:0];
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int n;
    longint m, v;
    n = nbytes(1'b1, f3);
    m = longint'(1) << (8 * n);
    v = (longint'(word) >> (8 * lane(n, addr))) % m;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    flush = 0; EX_valid = 0; EX_mem_read = 0; EX_mem_write = 0; EX_reg_write = 0;
    EX_funct3 = 0; EX_ALU_result = 0; EX_store_data = 0; EX_rd = 0; EX_PC = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic do_alu(input logic [31:0] res, input logic [4:0] rd, input bit regw,
                        input bit vld, input logic [31:0] pc);
    bit exp_we;
    exp_we = vld && regw && (rd != 0);
    EX_valid = vld; EX_mem_read = 0; EX_mem_write = 0; EX_reg_write = regw;
    EX_ALU_result = res; EX_rd = rd; EX_PC = pc;
    #1;
    checks++;
    if ({MEM_stall, dmem_req} !== 2'b00) begin
      errors++; $display("FAIL alu_nostall: stall/req=%b expected 00", {MEM_stall, dmem_req});
    end
    step();
    clear_ex();
    checks++;
    if (EX_MEM_reg_write_reg !== exp_we) begin
      errors++; $display("FAIL alu_we: got %b expected %b", EX_MEM_reg_write_reg, exp_we);
    end
    if (exp_we) begin
      checks++;
      if ({EX_RF_WR_Data_reg, EX_MEM_rd_reg, MEM_PC_reg} !== {res, rd, pc}) begin
        errors++; $display("FAIL alu_wb: data/rd/pc=%h/%0d/%h expected %h/%0d/%h",
                           EX_RF_WR_Data_reg, EX_MEM_rd_reg, MEM_PC_reg, res, rd, pc);
      end
    end
  endtask

  // gd = cycles with gnt low before the gnt cycle; rvd = cycles between gnt cycle+1 and rvalid
  task automatic do_mem(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] rd, input int gd,
                        input int rvd, input logic [31:0] word, input logic [31:0] pc);
    int n;
    bit exp_we;
    logic [31:0] eaddr;
    n = nbytes(ld, f3);
    eaddr = {addr[31:2], 2'b00};
    exp_we = ld && (rd != 0);
    EX_valid = 1; EX_mem_read = ld; EX_mem_write = !ld; EX_reg_write = ld;
    EX_funct3 = f3; EX_ALU_result = addr; EX_store_data = sd; EX_rd = rd; EX_PC = pc;
    for (int i = 0; i <= gd; i++) begin
      dmem_gnt = (i == gd);
      #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, !ld, eaddr, exp_be(n, addr)}) begin
        errors++; $display("FAIL mem_req: req/we/addr/be=%b/%b/%h/%b expected 1/%b/%h/%b",
                           dmem_req, dmem_we, dmem_addr, dmem_be, !ld, eaddr, exp_be(n, addr));
      end
      if (!ld) begin
        checks++;
        if (dmem_wdata !== exp_wdata(n, sd)) begin
          errors++; $display("FAIL mem_wdata: got %h expected %h", dmem_wdata, exp_wdata(n, sd));
        end
      end
      checks++;
      if (MEM_stall !== !(i == gd && !ld)) begin
        errors++; $display("FAIL mem_stall_req: got %b expected %b", MEM_stall, !(i == gd && !ld));
      end
      step();
    end
    dmem_gnt = 0;
    if (ld) begin
      for (int i = 0; i <= rvd; i++) begin
        dmem_rvalid = (i == rvd);
        dmem_rdata  = (i == rvd) ? word : $urandom;
        #1;
        checks++;
        if ({MEM_stall, dmem_req} !== {(i != rvd), 1'b0}) begin
          errors++; $display("FAIL mem_stall_resp: stall/req=%b%b expected %b0",
                             MEM_stall, dmem_req, (i != rvd));
        end
        step();
      end
    end
    clear_ex();
    checks++;
    if (EX_MEM_reg_write_reg !== exp_we) begin
      errors++; $display("FAIL mem_we: got %b expected %b", EX_MEM_reg_write_reg, exp_we);
    end
    if (exp_we) begin
      checks++;
      if ({EX_RF_WR_Data_reg, EX_MEM_rd_reg} !== {exp_load(f3, addr, word), rd}) begin
        errors++; $display("FAIL load_data: data/rd=%h/%0d expected %h/%0d",
                           EX_RF_WR_Data_reg, EX_MEM_rd_reg, exp_load(f3, addr, word), rd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; clear_ex();
    dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    repeat (2) step();
    checks++;
    if ({MEM_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
      errors++; $display("FAIL reset_dmem: stall/req/addr/be=%b/%b/%h/%b expected zeros",
                         MEM_stall, dmem_req, dmem_addr, dmem_be);
    end
    checks++;
    if ({EX_MEM_reg_write_reg, EX_MEM_rd_reg, EX_RF_WR_Data_reg, MEM_PC_reg} !== '0) begin
      errors++; $display("FAIL reset_wb: we/rd/data/pc=%b/%0d/%h/%h expected zeros",
                         EX_MEM_reg_write_reg, EX_MEM_rd_reg, EX_RF_WR_Data_reg, MEM_PC_reg);
    end
    checks++;
    if ({mem_trap, mem_trap_cause, mem_trap_tval} !== '0) begin
      errors++; $display("FAIL reset_trap: trap/cause/tval=%b/%0d/%h expected zeros",
                         mem_trap, mem_trap_cause, mem_trap_tval);
    end
    rst = 0;
    step();
    dmem_rvalid = 0;
    checks++;
    if ({EX_MEM_reg_write_reg, MEM_stall} !== 2'b00) begin
      errors++; $display("FAIL reset_stray_rvalid: we/stall=%b expected 00",
                         {EX_MEM_reg_write_reg, MEM_stall});
    end
  endtask

  task automatic test_alu();
    do_alu(32'h0000_1234, 5'd5, 1'b1, 1'b1, 32'h0000_0040);
    do_alu(32'hFFFF_0000, 5'd0, 1'b1, 1'b1, 32'h0000_0044);
    do_alu(32'h5555_AAAA, 5'd9, 1'b1, 1'b0, 32'h0000_0048);
  endtask

  task automatic test_load_lb();
    do_mem(1'b1, 3'd0, 32'h0000_0103, 32'h0, 5'd3, 0, 1, 32'h80FF_FFFF, 32'h100);
    do_mem(1'b1, 3'd4, 32'h0000_0103, 32'h0, 5'd3, 0, 0, 32'h80FF_FFFF, 32'h104);
    do_mem(1'b1, 3'd1, 32'h0000_0302, 32'h0, 5'd4, 1, 2, 32'h9234_5678, 32'h108);
    do_mem(1'b1, 3'd5, 32'h0000_0302, 32'h0, 5'd4, 0, 0, 32'h9234_5678, 32'h10C);
  endtask

  task automatic test_store_sh();
    do_mem(1'b0, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd6, 3, 0, 32'h0, 32'h200);
    do_mem(1'b0, 3'd0, 32'h0000_0201, 32'h1234_5677, 5'd6, 0, 0, 32'h0, 32'h204);
    do_mem(1'b0, 3'd2, 32'h0000_0204, 32'hCAFE_F00D, 5'd6, 1, 0, 32'h0, 32'h208);
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    EX_valid = 1; EX_mem_read = 1; EX_reg_write = 1; EX_funct3 = 3'd2;
    EX_ALU_result = 32'h0000_0101; EX_rd = 5'd8; dmem_gnt = 1;
    #1;
    checks++;
    if ({dmem_req, MEM_stall} !== 2'b00) begin
      errors++; $display("FAIL misalign_noreq: req/stall=%b expected 00", {dmem_req, MEM_stall});
    end
    step();
    clear_ex();
    checks++;
    if ({mem_trap, mem_trap_cause, mem_trap_tval, EX_MEM_reg_write_reg} !==
        {1'b1, 4'd4, 32'h0000_0101, 1'b0}) begin
      errors++; $display("FAIL misalign_load_trap: trap/cause/tval/we=%b/%0d/%h/%b expected 1/4/00000101/0",
                         mem_trap, mem_trap_cause, mem_trap_tval, EX_MEM_reg_write_reg);
    end
    EX_valid = 1; EX_mem_write = 1; EX_funct3 = 3'd1; EX_ALU_result = 32'h0000_0203;
    step();
    clear_ex();
    checks++;
    if ({mem_trap, mem_trap_cause, mem_trap_tval} !== {1'b1, 4'd6, 32'h0000_0203}) begin
      errors++; $display("FAIL misalign_store_trap: trap/cause/tval=%b/%0d/%h expected 1/6/00000203",
                         mem_trap, mem_trap_cause, mem_trap_tval);
    end
    step();
    checks++;
    if (mem_trap !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse: trap=%b expected 0", mem_trap);
    end
`else
    do_mem(1'b1, 3'd2, 32'h0000_0101, 32'h0, 5'd8, 0, 0, 32'h0BAD_F00D, 32'h300);
    do_mem(1'b0, 3'd1, 32'h0000_0203, 32'h0000_1357, 5'd8, 0, 0, 32'h0, 32'h304);
    checks++;
    if ({mem_trap, mem_trap_cause, mem_trap_tval} !== '0) begin
      errors++; $display("FAIL trap_tied_off: trap/cause/tval=%b/%0d/%h expected zeros",
                         mem_trap, mem_trap_cause, mem_trap_tval);
    end
`endif
  endtask

  task automatic test_flush();
    // flush while waiting for the response
    EX_valid = 1; EX_mem_read = 1; EX_reg_write = 1; EX_funct3 = 3'd2;
    EX_ALU_result = 32'h0000_0040; EX_rd = 5'd7; dmem_gnt = 1;
    step();
    dmem_gnt = 0; flush = 1;
    #1;
    checks++;
    if ({MEM_stall, dmem_req} !== 2'b10) begin
      errors++; $display("FAIL flush_resp_stall: stall/req=%b expected 10", {MEM_stall, dmem_req});
    end
    step();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_rvalid = (i == 2); dmem_rdata = 32'h1111_2222;
      #1;
      checks++;
      if (MEM_stall !== (i != 2)) begin
        errors++; $display("FAIL flush_resp_wait: cycle %0d stall=%b expected %b", i, MEM_stall, (i != 2));
      end
      step();
      checks++;
      if (EX_MEM_reg_write_reg !== 1'b0) begin
        errors++; $display("FAIL flush_resp_wb: cycle %0d we=%b expected 0", i, EX_MEM_reg_write_reg);
      end
    end
    clear_ex();
    do_mem(1'b1, 3'd2, 32'h0000_0044, 32'h0, 5'd7, 0, 1, 32'h3333_4444, 32'h400);
    // flush while the request is still ungranted
    EX_valid = 1; EX_mem_write = 1; EX_funct3 = 3'd2; EX_ALU_result = 32'h80;
    step();
    flush = 1;
    #1;
    checks++;
    if ({dmem_req, MEM_stall} !== 2'b00) begin
      errors++; $display("FAIL flush_req_drop: req/stall=%b expected 00", {dmem_req, MEM_stall});
    end
    step();
    clear_ex();
    do_alu(32'h0000_0777, 5'd2, 1'b1, 1'b1, 32'h408);
  endtask

  task automatic test_reset_mid();
    EX_valid = 1; EX_mem_read = 1; EX_reg_write = 1; EX_funct3 = 3'd2;
    EX_ALU_result = 32'h0000_0050; EX_rd = 5'd9;
    step();
    clear_ex();
    rst = 1;
    #1;
    checks++;
    if ({MEM_stall, dmem_req, EX_MEM_reg_write_reg, EX_RF_WR_Data_reg} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: stall/req/we=%b%b%b expected 000",
                         MEM_stall, dmem_req, EX_MEM_reg_write_reg);
    end
    step();
    rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hFEED_FACE;
    #1;
    checks++;
    if (MEM_stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stray_stall: stall=%b expected 0", MEM_stall);
    end
    step();
    dmem_rvalid = 0;
    checks++;
    if (EX_MEM_reg_write_reg !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stray_wb: we=%b expected 0", EX_MEM_reg_write_reg);
    end
    do_alu(32'h0000_0999, 5'd10, 1'b1, 1'b1, 32'h500);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 60; t++) begin
      int kind;
      logic [2:0] f3;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
`ifdef MISALIGN_TRAP_EN
      addr = addr & ~32'(nbytes(kind == 1, f3) - 1);
`endif
      if (kind == 0)
        do_alu($urandom, 5'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), $urandom);
      else
        do_mem(kind == 1, f3, addr, $urandom, 5'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_lb();
    test_store_sh();
    test_misalign();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
